uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo.sv | 128 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // Baud timer ticks per bit period; receiver and transmitter both count these.
    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// UART serial transmitter: pops one byte per frame from the TX FIFO and shifts it out LSB first.
// Latency: read_en to start bit is 2 clocks; a frame is (1+D_bit)*16 + stop_tick s_tick pulses.
// Backpressure: pops only in IDLE while the FIFO is non-empty; a frame in flight always completes.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   s_tick   one-cycle baud tick, 16 per bit period
//   empty    TX FIFO empty flag
//   data_in  TX FIFO read data, valid the cycle after read_en
//   read_en  FIFO pop strobe (combinational, one cycle per byte)
//   tx       registered serial line, idle high
//   tx_done  one-cycle pulse in the first IDLE cycle after a frame
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int D_bit     = 8,
    parameter int stop_tick = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_tick,
    input  logic             empty,
    input  logic [D_bit-1:0] data_in,
    output logic             read_en,
    output logic             tx,
    output logic             tx_done
);

    localparam int TICK_W = $clog2(max_int(OVERSAMPLE, stop_tick));
    localparam int BIT_W  = $clog2(D_bit);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(stop_tick - 1);
    localparam logic [TICK_W-1:0] TICK_INC  = {{(TICK_W-1){1'b0}}, 1'b1};
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(D_bit - 1);
    localparam logic [BIT_W-1:0]  BIT_INC   = {{(BIT_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [TICK_W-1:0] tick;
    logic [BIT_W-1:0]  bit_cnt;
    logic [D_bit-1:0]  shift;
    logic [D_bit-1:0]  shift_nxt;

    // Gated by rst so a FIFO entry is never consumed while the block is held in reset.
    assign read_en   = (state == IDLE) && !empty && !rst;
    assign shift_nxt = shift >> 1;

    // tx is registered and written on state transitions, so the line changes on the
    // same edge that consumes the last tick of the previous bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_done <= 1'b0;
            tick    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (read_en) begin
                        state <= FETCH;
                    end
                end

                // FIFO read data is valid now; the start bit goes out on this edge.
                FETCH: begin
                    shift <= data_in;
                    tick  <= '0;
                    tx    <= 1'b0;
                    state <= START;
                end

                START: begin
                    if (s_tick) begin
                        if (tick == TICK_LAST) begin
                            tick    <= '0;
                            bit_cnt <= '0;
                            tx      <= shift[0];
                            state   <= DATA;
                        end else begin
                            tick <= tick + TICK_INC;
                        end
                    end
                end

                DATA: begin
                    if (s_tick) begin
                        if (tick == TICK_LAST) begin
                            tick  <= '0;
                            shift <= shift_nxt;
                            if (bit_cnt == BIT_LAST) begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_INC;
                                tx      <= shift_nxt[0];
                            end
                        end else begin
                            tick <= tick + TICK_INC;
                        end
                    end
                end

                STOP: begin
                    if (s_tick) begin
                        if (tick == STOP_LAST) begin
                            tick    <= '0;
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            tick <= tick + TICK_INC;
                        end
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (16 and 32 stop ticks) share one FIFO model;
// sel picks which instance may pop and which one the line monitor decodes.
module tb_uart_tx_fifo;

    localparam int CLK_P = 10;
    localparam int HALF  = CLK_P / 2;

    typedef struct {
        logic [7:0] data;
        int         stop_ticks;
        int         tick_div;
        bit         aborted;
    } exp_t;

    logic clk = 1'b0;
    always #HALF clk = ~clk;

    logic       rst     = 1'b1;
    logic       s_tick  = 1'b1;
    logic       q_empty = 1'b1;
    logic       sel     = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic empty_a, empty_b;
    logic read_en_a, read_en_b, tx_a, tx_b, tx_done_a, tx_done_b;
    logic m_read_en, m_tx, m_tx_done;

    assign empty_a   = q_empty | sel;
    assign empty_b   = q_empty | ~sel;
    assign m_read_en = sel ? read_en_b : read_en_a;
    assign m_tx      = sel ? tx_b      : tx_a;
    assign m_tx_done = sel ? tx_done_b : tx_done_a;

    uart_tx_fifo #(.D_bit(8), .stop_tick(16)) dut_a (
        .clk(clk), .rst(rst), .s_tick(s_tick), .empty(empty_a), .data_in(data_in),
        .read_en(read_en_a), .tx(tx_a), .tx_done(tx_done_a)
    );

    uart_tx_fifo #(.D_bit(8), .stop_tick(32)) dut_b (
        .clk(clk), .rst(rst), .s_tick(s_tick), .empty(empty_b), .data_in(data_in),
        .read_en(read_en_b), .tx(tx_b), .tx_done(tx_done_b)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];
    int         tick_div = 1;
    int         rd_count = 0;
    time        rd_time  = 0;
    bit         coin     = 1'b0;
    bit         pending  = 1'b0;
    bit         in_frame = 1'b0;
    bit         idle_bad = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit ab);
        exp_t e;
        e.data       = b;
        e.stop_ticks = sel ? 32 : 16;
        e.tick_div   = tick_div;
        e.aborted    = ab;
        fifo_q.push_back(b);
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || in_frame) && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || in_frame) begin
            n_fail++;
            $display("FAIL drain: %0d frames outstanding after %0d clocks, required 0",
                     exp_q.size() + (in_frame ? 1 : 0), budget);
        end
    endtask

    // Baud tick: one pulse every tick_div clocks, changed on the falling edge.
    initial begin : tick_gen
        int ph = 0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % tick_div;
            s_tick = (ph == 0);
        end
    end

    // FIFO model: a pop seen mid-cycle presents data on the next (FETCH) cycle;
    // the empty flag only moves just after a rising edge.
    initial begin : fifo_model
        forever begin
            @(negedge clk);
            if (pending) begin
                data_in = fifo_q.pop_front();
                pending = 1'b0;
            end else if (m_read_en === 1'b1) begin
                pending = 1'b1;
                rd_count++;
                rd_time = $time;
                coin    = (m_tx_done === 1'b1);
            end
            @(posedge clk);
            #1;
            q_empty = (fifo_q.size() == 0);
        end
    end

    // Line monitor: decodes each frame in the tick domain and checks it against the scoreboard.
    initial begin : monitor
        exp_t       it;
        bit         tk, rr, glitch, early, aborted, tmo;
        logic       prev, req_lvl;
        logic [9:0] seg_bad, seg_lvl;
        int         n, total, guard, seg, fnum;
        time        fall_t, done_t;
        fnum = 0;
        forever begin
            @(posedge clk);
            tk = s_tick;
            rr = rst;
            #1;
            if (m_tx_done === 1'b1) idle_bad = 1'b1;
            if (!rr && m_tx === 1'b0) begin
                in_frame = 1'b1;
                fall_t   = $time - 1;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame%0d: start bit with empty scoreboard, required no frame", fnum);
                    it.data       = 8'h00;
                    it.stop_ticks = sel ? 32 : 16;
                    it.tick_div   = tick_div;
                    it.aborted    = 1'b0;
                end else begin
                    it = exp_q.pop_front();
                end
                check($sformatf("frame%0d read_en to start clocks", fnum),
                      32'(int'((fall_t - (rd_time - HALF)) / CLK_P)), 32'd2);

                prev    = 1'b0;
                n       = 0;
                total   = 144 + it.stop_ticks;
                guard   = 0;
                seg_bad = '0;
                seg_lvl = '0;
                glitch  = 1'b0;
                early   = 1'b0;
                aborted = 1'b0;
                tmo     = 1'b0;
                while (n < total) begin
                    @(posedge clk);
                    tk = s_tick;
                    rr = rst;
                    #1;
                    guard++;
                    if (rr) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (guard > total * it.tick_div + 64) begin
                        tmo = 1'b1;
                        break;
                    end
                    if (tk) begin
                        n++;
                        seg = (n - 1) / 16;
                        if (seg > 9) seg = 9;
                        req_lvl = (seg == 0) ? 1'b0 : (seg == 9) ? 1'b1 : it.data[seg-1];
                        if (prev !== req_lvl) begin
                            seg_bad[seg] = 1'b1;
                            seg_lvl[seg] = prev;
                        end
                    end else if (m_tx !== prev) begin
                        glitch = 1'b1;
                    end
                    if (m_tx_done === 1'b1 && n < total) early = 1'b1;
                    prev = m_tx;
                end
                done_t = $time - 1;

                check($sformatf("frame%0d aborted by reset", fnum), 32'(aborted), 32'(it.aborted));
                if (tmo) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame%0d timeout: %0d ticks seen, required %0d", fnum, n, total);
                end else if (!aborted) begin
                    for (int s = 0; s < 10; s++) begin
                        req_lvl = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : it.data[s-1];
                        n_checks++;
                        if (seg_bad[s]) begin
                            n_fail++;
                            $display("FAIL frame%0d seg%0d: line level %b, required %b",
                                     fnum, s, seg_lvl[s], req_lvl);
                        end
                    end
                    check($sformatf("frame%0d tx_done at end", fnum), 32'(m_tx_done), 32'd1);
                    check($sformatf("frame%0d tx_done early", fnum), 32'(early), 32'd0);
                    check($sformatf("frame%0d tx change off tick", fnum), 32'(glitch), 32'd0);
                    if (it.tick_div == 1)
                        check($sformatf("frame%0d read_en to tx_done clocks", fnum),
                              32'(int'((done_t - (rd_time - HALF)) / CLK_P)),
                              32'(2 + 144 + it.stop_ticks));
                end
                in_frame = 1'b0;
                fnum++;
            end
        end
    end

    initial begin : stim
        bit re_seen, tx_bad, done_bad;
        int base, k;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset tx_a", 32'(tx_a), 32'd1);
        check("reset tx_done_a", 32'(tx_done_a), 32'd0);
        check("reset read_en_a", 32'(read_en_a), 32'd0);
        check("reset tx_b", 32'(tx_b), 32'd1);
        check("reset tx_done_b", 32'(tx_done_b), 32'd0);
        rst = 1'b0;

        // Empty FIFO for 500 clocks: nothing moves
        re_seen = 1'b0; tx_bad = 1'b0; done_bad = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (m_read_en !== 1'b0) re_seen = 1'b1;
            if (m_tx !== 1'b1) tx_bad = 1'b1;
            if (m_tx_done !== 1'b0) done_bad = 1'b1;
        end
        check("empty: read_en seen", 32'(re_seen), 32'd0);
        check("empty: tx left idle", 32'(tx_bad), 32'd0);
        check("empty: tx_done seen", 32'(done_bad), 32'd0);

        // Single byte, tick every clock
        base = rd_count;
        send(8'hA5, 1'b0);
        drain(600);
        check("single byte pop count", 32'(rd_count - base), 32'd1);

        // Back-to-back frames: second pop lands in the tx_done cycle
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        drain(1000);
        check("b2b second read_en with tx_done", 32'(coin), 32'd1);

        // Reset in the middle of data bit 3; the popped byte is dropped
        base = rd_count;
        send(8'h3C, 1'b1);
        send(8'hC3, 1'b0);
        k = 0;
        while (rd_count == base && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("reset test: pop seen", 32'(rd_count != base), 32'd1);
        repeat (72) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid-frame reset tx", 32'(tx_a), 32'd1);
        check("mid-frame reset tx_done", 32'(tx_done_a), 32'd0);
        check("mid-frame reset read_en", 32'(read_en_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drain(600);

        // Slow tick (every 4 clocks) on the 32-stop-tick instance
        @(posedge clk);
        #1;
        sel      = 1'b1;
        tick_div = 4;
        send(8'h55, 1'b0);
        send(8'h3C, 1'b0);
        send(8'h81, 1'b0);
        drain(3 * (176 * 4 + 64));
        @(posedge clk);
        #1;
        sel      = 1'b0;
        tick_div = 1;

        check("tx_done outside a frame", 32'(idle_bad), 32'd0);
        check("fifo model drained", 32'(fifo_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
